// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - op encoding, address defaults and op classification for dm_port
package dm_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8,
    OP_ALU  = 4'd9
  } op_e;

  localparam logic [31:0] DATA_LIMIT_DEF = 32'h0000_3000;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;

  function automatic logic is_load(input op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_store(input op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/load_ext.sv
// rtl/load_ext.sv - lane select and sign/zero extension of a loaded word
module load_ext
  import dm_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  op_e         op,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  always_comb begin
    half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
  end

  always_comb begin
    data = '0;
    case (op)
      OP_LW:   data = rdata;
      OP_LH:   data = {{16{half[15]}}, half};
      OP_LHU:  data = {16'h0000, half};
      OP_LB:   data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  data = {24'h000000, byte_v};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dm_port.sv
// rtl/dm_port.sv - M/W pipeline registers and data-memory initiator of the core
module dm_port
  import dm_pkg::*;
#(
  parameter logic [31:0] DATA_LIMIT = DATA_LIMIT_DEF,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [31:0] e_pc,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_addr,
  input  logic [31:0] e_store_data,
  input  logic [31:0] e_wb_data,
  input  logic [4:0]  e_rd,
  input  logic        m_hold,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_inst_addr,
  output logic        m_misalign,
  output logic        w_grf_we,
  output logic [4:0]  w_grf_addr,
  output logic [31:0] w_grf_wdata,
  output logic [31:0] w_inst_addr
);

  logic        m_valid;
  op_e         m_op;
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic [31:0] m_wb;
  logic [4:0]  m_rd;
  logic        m_sent;

  // m_sent marks that the op has already spent its first M cycle, so a held
  // store writes exactly once and misalign pulses exactly once.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_op    <= OP_NONE;
      m_pc    <= RESET_PC;
      m_addr  <= '0;
      m_data  <= '0;
      m_wb    <= '0;
      m_rd    <= '0;
      m_sent  <= 1'b0;
    end else if (!m_hold) begin
      m_sent <= 1'b0;
      if (e_valid) begin
        m_valid <= 1'b1;
        m_op    <= op_e'(e_op);
        m_pc    <= e_pc;
        m_addr  <= e_addr;
        m_data  <= e_store_data;
        m_wb    <= e_wb_data;
        m_rd    <= e_rd;
      end else begin
        m_valid <= 1'b0;
        m_op    <= OP_NONE;
        m_pc    <= RESET_PC;
        m_addr  <= '0;
        m_data  <= '0;
        m_wb    <= '0;
        m_rd    <= '0;
      end
    end else begin
      m_sent <= m_valid;
    end
  end

  logic        m_aligned;
  logic        m_legal;
  logic [31:0] ld_data;

  always_comb begin
    case (m_op)
      OP_LW, OP_SW:         m_aligned = (m_addr[1:0] == 2'b00);
      OP_LH, OP_LHU, OP_SH: m_aligned = !m_addr[0];
      default:              m_aligned = 1'b1;
    endcase
    m_legal = !(is_load(m_op) || is_store(m_op)) ||
              (m_aligned && (m_addr < DATA_LIMIT));
  end

  always_comb begin
    m_data_byteen = 4'b0000;
    if (m_valid && m_legal && !m_sent) begin
      case (m_op)
        OP_SW:   m_data_byteen = 4'b1111;
        OP_SH:   m_data_byteen = m_addr[1] ? 4'b1100 : 4'b0011;
        OP_SB:   m_data_byteen = 4'b0001 << m_addr[1:0];
        default: m_data_byteen = 4'b0000;
      endcase
    end
  end

  always_comb begin
    case (m_op)
      OP_SW:   m_data_wdata = m_data;
      OP_SH:   m_data_wdata = {2{m_data[15:0]}};
      OP_SB:   m_data_wdata = {4{m_data[7:0]}};
      default: m_data_wdata = '0;
    endcase
  end

  assign m_data_addr = m_addr;
  assign m_inst_addr = m_pc;
  assign m_misalign  = m_valid && !m_sent && !m_legal;

  load_ext u_load_ext (
    .rdata   (m_data_rdata),
    .addr_lo (m_addr[1:0]),
    .op      (m_op),
    .data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset || m_hold || !m_valid) begin
      w_grf_we    <= 1'b0;
      w_grf_addr  <= '0;
      w_grf_wdata <= '0;
      w_inst_addr <= RESET_PC;
    end else begin
      w_grf_we    <= (is_load(m_op) || (m_op == OP_ALU)) && m_legal && (m_rd != 5'd0);
      w_grf_addr  <= m_rd;
      w_grf_wdata <= (m_op == OP_ALU) ? m_wb : ld_data;
      w_inst_addr <= m_pc;
    end
  end

endmodule

// File: tb/tb_dm_port.sv
// tb/tb_dm_port.sv - directed plus randomized check of dm_port against a reference model
module tb_dm_port;

  localparam logic [31:0] LIMIT = 32'h0000_3000;
  localparam logic [31:0] RPC   = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        e_valid = 1'b0;
  logic [31:0] e_pc = '0;
  logic [3:0]  e_op = '0;
  logic [31:0] e_addr = '0;
  logic [31:0] e_store_data = '0;
  logic [31:0] e_wb_data = '0;
  logic [4:0]  e_rd = '0;
  logic        m_hold = 1'b0;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata = '0;
  logic [31:0] m_inst_addr;
  logic        m_misalign;
  logic        w_grf_we;
  logic [4:0]  w_grf_addr;
  logic [31:0] w_grf_wdata;
  logic [31:0] w_inst_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_port dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_pc(e_pc), .e_op(e_op),
    .e_addr(e_addr), .e_store_data(e_store_data), .e_wb_data(e_wb_data),
    .e_rd(e_rd), .m_hold(m_hold), .m_data_addr(m_data_addr),
    .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_data_rdata(m_data_rdata), .m_inst_addr(m_inst_addr),
    .m_misalign(m_misalign), .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr),
    .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr)
  );

  // Reference model: the instruction sitting in M and the last write-back.
  bit          mv, msent;
  int          mop;
  logic [31:0] mpc, maddr, mdata, mwb;
  logic [4:0]  mrd;
  bit          xwe;
  logic [4:0]  xrd;
  logic [31:0] xdata, xpc;

  function automatic bit legal(int op, logic [31:0] a);
    bit mem;
    bit al;
    mem = (op >= 1 && op <= 8);
    if (op == 1 || op == 6) al = (a % 4 == 0);
    else if (op == 2 || op == 3 || op == 7) al = (a % 2 == 0);
    else al = 1;
    return !mem || (al && a < LIMIT);
  endfunction

  function automatic logic [31:0] exp_be();
    if (!mv || msent || !legal(mop, maddr)) return 0;
    if (mop == 6) return 32'hF;
    if (mop == 7) return (maddr % 4 >= 2) ? 32'hC : 32'h3;
    if (mop == 8) return 32'd1 << (maddr % 4);
    return 0;
  endfunction

  function automatic logic [31:0] exp_wdata();
    if (mop == 6) return mdata;
    if (mop == 7) return (mdata % 32'h10000) * 32'h0001_0001;
    if (mop == 8) return (mdata % 32'h100) * 32'h0101_0101;
    return 0;
  endfunction

  function automatic logic [31:0] load_val(int op, logic [31:0] a, logic [31:0] rd_word);
    logic [31:0] h, b;
    h = (rd_word >> (16 * ((a / 2) % 2))) % 32'h10000;
    b = (rd_word >> (8 * (a % 4))) % 32'h100;
    case (op)
      1: return rd_word;
      2: return (h >= 32'h8000) ? h - 32'h10000 : h;
      3: return h;
      4: return (b >= 32'h80) ? b - 32'h100 : b;
      5: return b;
      9: return mwb;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit wv;
    wv = !reset && !m_hold && mv;
    xwe   = wv && ((mop >= 1 && mop <= 5) || mop == 9) && legal(mop, maddr) && mrd != 0;
    xrd   = mrd;
    xdata = load_val(mop, maddr, m_data_rdata);
    xpc   = wv ? mpc : RPC;
    if (reset || (!m_hold && !e_valid)) begin
      mv = 0; mop = 0; mpc = RPC; maddr = 0; mdata = 0; mwb = 0; mrd = 0; msent = 0;
    end else if (!m_hold) begin
      mv = 1; mop = int'(e_op); mpc = e_pc; maddr = e_addr; mdata = e_store_data;
      mwb = e_wb_data; mrd = e_rd; msent = 0;
    end else begin
      msent = mv;
    end
    @(posedge clk);
    #1;
    chk("byteen", 32'(m_data_byteen), exp_be());
    chk("wdata", m_data_wdata, exp_wdata());
    chk("data_addr", m_data_addr, maddr);
    chk("m_inst_addr", m_inst_addr, mpc);
    chk("misalign", 32'(m_misalign), 32'(mv && !msent && !legal(mop, maddr)));
    chk("grf_we", 32'(w_grf_we), 32'(xwe));
    chk("w_inst_addr", w_inst_addr, xpc);
    if (xwe) begin
      chk("grf_addr", 32'(w_grf_addr), 32'(xrd));
      chk("grf_wdata", w_grf_wdata, xdata);
    end
  endtask

  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    e_valid = 1; e_op = 4'(op); e_addr = a; e_store_data = d; e_rd = rd;
    e_wb_data = $urandom; e_pc = 32'h0000_3400 + 4 * $urandom_range(0, 255);
    tick();
  endtask

  task automatic bubble();
    e_valid = 0;
    tick();
  endtask

  initial begin
    reset = 1;
    tick();
    reset = 0;
    chk("rst_byteen", 32'(m_data_byteen), 0);
    chk("rst_grf_addr", 32'(w_grf_addr), 0);
    chk("rst_grf_wdata", w_grf_wdata, 0);
    chk("rst_w_inst", w_inst_addr, RPC);
    chk("rst_m_inst", m_inst_addr, RPC);

    issue(6, 32'h10, 32'h1234_5678, 5'd3);
    chk("sw_be", 32'(m_data_byteen), 32'hF);
    chk("sw_wdata", m_data_wdata, 32'h1234_5678);
    issue(8, 32'h13, 32'h0000_00AB, 5'd3);
    chk("sb_be", 32'(m_data_byteen), 32'h8);
    chk("sb_wdata", m_data_wdata, 32'hABAB_ABAB);
    chk("sw_no_we", 32'(w_grf_we), 0);
    issue(7, 32'h6, 32'h0000_BEEF, 5'd3);
    chk("sh_be", 32'(m_data_byteen), 32'hC);

    issue(4, 32'h13, 0, 5'd5);
    m_data_rdata = 32'h8000_0000;
    issue(5, 32'h13, 0, 5'd6);
    chk("lb_val", w_grf_wdata, 32'hFFFF_FF80);
    chk("lb_addr", 32'(w_grf_addr), 5);
    issue(3, 32'h2, 0, 5'd7);
    chk("lbu_val", w_grf_wdata, 32'h0000_0080);
    m_data_rdata = 32'h8001_0000;
    issue(2, 32'h2, 0, 5'd8);
    chk("lhu_val", w_grf_wdata, 32'h0000_8001);
    issue(1, 32'h0, 0, 5'd0);
    chk("lh_val", w_grf_wdata, 32'hFFFF_8001);
    bubble();
    chk("lw_r0_we", 32'(w_grf_we), 0);

    issue(6, 32'h20, 32'hCAFE_F00D, 5'd1);
    m_hold = 1; e_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_be", 32'(m_data_byteen), 0);
      chk("held_w_bubble", w_inst_addr, RPC);
    end
    m_hold = 0;
    bubble();

    issue(1, 32'h2, 0, 5'd4);
    chk("lw_mis", 32'(m_misalign), 1);
    issue(6, 32'h3000, 32'h1, 5'd4);
    chk("sw_limit_be", 32'(m_data_byteen), 0);
    bubble();
    chk("mis_pulse_end", 32'(m_misalign), 0);

    issue(8, 32'h11, 32'h55, 5'd2);
    m_hold = 1; e_valid = 0;
    tick();
    reset = 1;
    tick();
    reset = 0; m_hold = 0;
    tick();
    chk("rst_drop_be", 32'(m_data_byteen), 0);

    for (int i = 0; i < 400; i++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r == 0) a = LIMIT + $urandom_range(0, 255);
      else if (r == 1) a = $urandom;
      else a = $urandom_range(0, 255);
      e_valid = ($urandom_range(0, 99) < 85);
      e_op = 4'($urandom_range(0, 9));
      e_addr = a;
      e_store_data = $urandom;
      e_wb_data = $urandom;
      e_rd = 5'($urandom);
      e_pc = $urandom;
      m_hold = ($urandom_range(0, 99) < 25);
      reset = ($urandom_range(0, 99) < 3);
      m_data_rdata = $urandom;
      tick();
    end
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
